// File: rtl/fpmul_pipe.sv
// fpmul_pipe: fully pipelined floating-point multiplier with valid/tag sideband,
// pipeline clock-enable, round-to-nearest-even and special-value handling.
// Latency is MUL_STAGES+2 enabled cycles; one operation accepted per enabled cycle.
module fpmul_pipe #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int MUL_STAGES = 1,
    parameter int TAG_W      = 4,
    localparam int W         = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [W-1:0]     res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_inv
);

    // Exponent carried signed with two guard bits so overflow/underflow never wraps.
    localparam int EW = EXP_W + 2;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0] EONE = EW'(1);
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             sign;
        logic [EW-1:0]    exp;
        logic             inv;
        logic             inf;
        logic             zero;
    } side_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             sign;
        logic [EW-1:0]    exp;
        logic [MAN_W-1:0] man;
        logic             inv;
        logic             inf;
        logic             zero;
    } nrm_t;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             za, zb, ia, ib, na, nb;
    side_t            side_d;
    logic [PW-1:0]    prod_d;
    side_t            side_q [MUL_STAGES];
    logic [PW-1:0]    prod_q [MUL_STAGES];

    side_t            sd;
    logic [PW-1:0]    p;
    logic [MAN_W-1:0] man;
    logic             guard, sticky, inc;
    logic [EW-1:0]    exp_n;
    logic [MAN_W:0]   rnd;
    nrm_t             nrm_d, nrm_q;

    logic             valid_d, ovf_d, unf_d, inv_d;
    logic [W-1:0]     res_d;
    logic [TAG_W-1:0] tag_d;
    logic             valid_q, ovf_q, unf_q, inv_q;
    logic [W-1:0]     res_q;
    logic [TAG_W-1:0] tag_q;

    // Stage 0: operand decode, sign and biased exponent sum, significand product
    always_comb begin
        ea = a[W-2 -: EXP_W];
        eb = b[W-2 -: EXP_W];
        ma = a[MAN_W-1:0];
        mb = b[MAN_W-1:0];
        za = (ea == '0);
        zb = (eb == '0);
        ia = (&ea) && (ma == '0);
        ib = (&eb) && (mb == '0);
        na = (&ea) && (ma != '0);
        nb = (&eb) && (mb != '0);
        side_d.valid = in_valid;
        side_d.tag   = in_tag;
        side_d.sign  = a[W-1] ^ b[W-1];
        side_d.exp   = {2'b00, ea} + {2'b00, eb} - BIAS;
        side_d.inv   = na | nb | (ia & zb) | (ib & za);
        side_d.inf   = ia | ib;
        side_d.zero  = za | zb;
        prod_d = PW'({1'b1, ma}) * PW'({1'b1, mb});
    end

    // Multiplier pipeline with the decoded sideband travelling alongside
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < MUL_STAGES; k++) begin
                side_q[k] <= '0;
                prod_q[k] <= '0;
            end
        end else if (ce) begin
            side_q[0] <= side_d;
            prod_q[0] <= prod_d;
            for (int k = 1; k < MUL_STAGES; k++) begin
                side_q[k] <= side_q[k-1];
                prod_q[k] <= prod_q[k-1];
            end
        end
    end

    // Normalise by at most one position, then round to nearest even
    always_comb begin
        p      = prod_q[MUL_STAGES-1];
        sd     = side_q[MUL_STAGES-1];
        man    = p[PW-3 -: MAN_W];
        guard  = p[MAN_W-1];
        sticky = |p[MAN_W-2:0];
        exp_n  = sd.exp;
        if (p[PW-1]) begin
            man    = p[PW-2 -: MAN_W];
            guard  = p[MAN_W];
            sticky = |p[MAN_W-1:0];
            exp_n  = sd.exp + EONE;
        end
        inc = guard & (sticky | man[0]);
        rnd = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        nrm_d.valid = sd.valid;
        nrm_d.tag   = sd.tag;
        nrm_d.sign  = sd.sign;
        // A rounding carry leaves the mantissa bits at zero, so only the exponent moves.
        nrm_d.exp   = exp_n + (rnd[MAN_W] ? EONE : '0);
        nrm_d.man   = rnd[MAN_W-1:0];
        nrm_d.inv   = sd.inv;
        nrm_d.inf   = sd.inf;
        nrm_d.zero  = sd.zero;
    end

    // Normalise/round stage register
    always_ff @(posedge clk) begin
        if (!rst) begin
            nrm_q <= '0;
        end else if (ce) begin
            nrm_q <= nrm_d;
        end
    end

    // Result classification; bubbles pack to all-zero so idle outputs stay deterministic
    always_comb begin
        valid_d = nrm_q.valid;
        tag_d   = '0;
        res_d   = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        inv_d   = 1'b0;
        if (nrm_q.valid) begin
            tag_d = nrm_q.tag;
            if (nrm_q.inv) begin
                res_d = QNAN;
                inv_d = 1'b1;
            end else if (nrm_q.inf) begin
                res_d = {nrm_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (nrm_q.zero) begin
                res_d = {nrm_q.sign, {(W-1){1'b0}}};
            end else if ($signed(nrm_q.exp) >= $signed(EMAX)) begin
                res_d = {nrm_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                ovf_d = 1'b1;
            end else if ($signed(nrm_q.exp) < $signed(EONE)) begin
                res_d = {nrm_q.sign, {(W-1){1'b0}}};
                unf_d = 1'b1;
            end else begin
                res_d = {nrm_q.sign, nrm_q.exp[EXP_W-1:0], nrm_q.man};
            end
        end
    end

    // Output pack register
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            tag_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else if (ce) begin
            valid_q <= valid_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inv_q   <= inv_d;
        end
    end

    assign out_valid = valid_q;
    assign res       = res_q;
    assign out_tag   = tag_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;
    assign out_inv   = inv_q;

endmodule

// File: tb/tb_fpmul_pipe.sv
// Bench for fpmul_pipe: directed single-precision cases plus a half-precision
// instance with a deeper multiplier, both scoreboarded against an integer model.
module tb_fpmul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ce;

    logic        v0, ov0, ovf0, unf0, inv0;
    logic [31:0] a0, b0, res0;
    logic [3:0]  tag0, ot0;

    logic        v1, ov1, ovf1, unf1, inv1;
    logic [15:0] a1, b1, res1;
    logic [3:0]  tag1, ot1;

    fpmul_pipe u0 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v0), .a(a0), .b(b0), .in_tag(tag0),
        .out_valid(ov0), .res(res0), .out_tag(ot0), .out_ovf(ovf0), .out_unf(unf0), .out_inv(inv0)
    );

    fpmul_pipe #(.EXP_W(5), .MAN_W(10), .MUL_STAGES(3), .TAG_W(4)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v1), .a(a1), .b(b1), .in_tag(tag1),
        .out_valid(ov1), .res(res1), .out_tag(ot1), .out_ovf(ovf1), .out_unf(unf1), .out_inv(inv1)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;   // {ovf, unf, inv}
        int          cyc;
    } sb_t;

    sb_t  q0[$], q1[$];
    sb_t  x0, x1, m0, m1, l0, l1;
    int   total = 0;
    int   bad = 0;
    int   ecyc = 0;
    logic upd = 1'b0, stl = 1'b0;
    logic hv0 = 1'b0, hv1 = 1'b0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", nm, obs, exp);
        end
    endtask

    // Integer reference: exact product, leading-one detect, remainder-vs-half rounding.
    function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int E, input int M);
        longint emax, bias, hid, ea, eb, ma, mb, sig, q, rem, half, e, sgn;
        int     sh;
        logic   za, zb, ia, ib, na, nb;
        emax = (longint'(1) << E) - 1;
        bias = (longint'(1) << (E - 1)) - 1;
        hid  = longint'(1) << M;
        ea   = (longint'(a) >> M) & emax;
        eb   = (longint'(b) >> M) & emax;
        ma   = longint'(a) & (hid - 1);
        mb   = longint'(b) & (hid - 1);
        sgn  = longint'(a[E+M] ^ b[E+M]);
        za = (ea == 0);  zb = (eb == 0);
        ia = (ea == emax) && (ma == 0);  ib = (eb == emax) && (mb == 0);
        na = (ea == emax) && (ma != 0);  nb = (eb == emax) && (mb != 0);
        if (na || nb || (ia && zb) || (ib && za))
            return {3'b001, 32'((emax << M) | (hid >> 1))};
        if (ia || ib)
            return {3'b000, 32'((sgn << (E + M)) | (emax << M))};
        if (za || zb)
            return {3'b000, 32'(sgn << (E + M))};
        sig = (hid | ma) * (hid | mb);
        e   = ea + eb - bias;
        if (sig >= (longint'(1) << (2 * M + 1))) begin
            sh = M + 1;
            e  = e + 1;
        end else begin
            sh = M;
        end
        q    = sig >> sh;
        rem  = sig & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q & 1) != 0)) q = q + 1;
        if (q == (hid << 1)) begin
            q = hid;
            e = e + 1;
        end
        if (e >= emax) return {3'b100, 32'((sgn << (E + M)) | (emax << M))};
        if (e <= 0)    return {3'b010, 32'(sgn << (E + M))};
        return {3'b000, 32'((sgn << (E + M)) | (e << M) | (q - hid))};
    endfunction

    function automatic logic [31:0] rnd_op(input int E, input int M);
        longint emax, e, m, s;
        emax = (longint'(1) << E) - 1;
        s = longint'($urandom_range(0, 1));
        m = longint'($urandom) & ((longint'(1) << M) - 1);
        case ($urandom_range(0, 7))
            0:       e = 0;
            1:       begin e = emax; m = 0; end
            2:       e = emax;
            3:       e = emax - 1 - longint'($urandom_range(0, 3));
            4:       e = 1 + longint'($urandom_range(0, 3));
            default: e = longint'($urandom_range(0, int'(emax)));
        endcase
        return 32'((s << (E + M)) | (e << M) | m);
    endfunction

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                          input logic [31:0] r, input logic [2:0] f);
        v0 = 1'b1; a0 = a; b0 = b; tag0 = t;
        x0.res = r; x0.tag = t; x0.flg = f;
    endtask

    task automatic drive1(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                          input logic [31:0] r, input logic [2:0] f);
        v1 = 1'b1; a1 = a; b1 = b; tag1 = t;
        x1.res = r; x1.tag = t; x1.flg = f;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            step();
            n++;
        end
        total++;
        assert (q0.size() == 0 && q1.size() == 0) else begin
            bad++;
            $error("FAIL drain: pending u0=%0d u1=%0d, want 0/0", q0.size(), q1.size());
        end
    endtask

    // Scoreboard push on every accepted operation; reset discards anything in flight.
    always @(posedge clk) begin
        if (!rst) begin
            q0.delete();
            q1.delete();
        end else if (ce) begin
            if (v0) q0.push_back('{res: x0.res, tag: x0.tag, flg: x0.flg, cyc: ecyc});
            if (v1) q1.push_back('{res: x1.res, tag: x1.tag, flg: x1.flg, cyc: ecyc});
            ecyc <= ecyc + 1;
        end
        upd <= rst && ce;
        stl <= rst && !ce;
    end

    always @(negedge clk) begin
        if (upd && ov0) begin
            if (q0.size() == 0) begin
                chk("u0_stray", 64'(ov0), 64'(0));
            end else begin
                m0 = q0.pop_front();
                chk("u0_res", 64'(res0), 64'(m0.res));
                chk("u0_flags", 64'({ovf0, unf0, inv0}), 64'(m0.flg));
                chk("u0_tag", 64'(ot0), 64'(m0.tag));
                chk("u0_lat", 64'(ecyc - m0.cyc), 64'(3));
                l0 <= m0;
            end
        end
        if (stl) begin
            chk("u0_hold_valid", 64'(ov0), 64'(hv0));
            if (hv0) chk("u0_hold_res", 64'({res0, ot0, ovf0, unf0, inv0}), 64'({l0.res, l0.tag, l0.flg}));
        end
        if (upd) hv0 <= ov0;
        else if (!stl) hv0 <= 1'b0;
    end

    always @(negedge clk) begin
        if (upd && ov1) begin
            if (q1.size() == 0) begin
                chk("u1_stray", 64'(ov1), 64'(0));
            end else begin
                m1 = q1.pop_front();
                chk("u1_res", 64'(res1), 64'(m1.res));
                chk("u1_flags", 64'({ovf1, unf1, inv1}), 64'(m1.flg));
                chk("u1_tag", 64'(ot1), 64'(m1.tag));
                chk("u1_lat", 64'(ecyc - m1.cyc), 64'(5));
                l1 <= m1;
            end
        end
        if (stl) begin
            chk("u1_hold_valid", 64'(ov1), 64'(hv1));
            if (hv1) chk("u1_hold_res", 64'({res1, ot1, ovf1, unf1, inv1}), 64'({l1.res[15:0], l1.tag, l1.flg}));
        end
        if (upd) hv1 <= ov1;
        else if (!stl) hv1 <= 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [34:0] r;
        rst = 1'b0; ce = 1'b1;
        v0 = 1'b0; a0 = '0; b0 = '0; tag0 = '0;
        v1 = 1'b0; a1 = '0; b1 = '0; tag1 = '0;
        x0 = '{res: '0, tag: '0, flg: '0, cyc: 0};
        x1 = '{res: '0, tag: '0, flg: '0, cyc: 0};
        repeat (3) step();
        chk("rst_valid", 64'(ov0), 64'(0));
        chk("rst_res", 64'(res0), 64'(0));
        chk("rst_tag", 64'(ot0), 64'(0));
        chk("rst_flags", 64'({ovf0, unf0, inv0}), 64'(0));
        chk("rst_valid_u1", 64'(ov1), 64'(0));
        rst = 1'b1;

        // Back-to-back stream: normal, RNE, signed zero and special values
        drive0(32'h3FC00000, 32'h40000000, 4'd1, 32'h40400000, 3'b000); step();
        drive0(32'h3F800001, 32'h3F800001, 4'd2, 32'h3F800002, 3'b000); step();
        drive0(32'h3F800001, 32'h3FC00000, 4'd3, 32'h3FC00002, 3'b000); step();
        drive0(32'h80000000, 32'h3F800000, 4'd4, 32'h80000000, 3'b000); step();
        drive0(32'h7F000000, 32'h7F000000, 4'd5, 32'h7F800000, 3'b100); step();
        drive0(32'h00800000, 32'h00800000, 4'd6, 32'h00000000, 3'b010); step();
        drive0(32'h7F800000, 32'h00000000, 4'd7, 32'h7FC00000, 3'b001); step();
        drive0(32'hFF800000, 32'h40000000, 4'd8, 32'hFF800000, 3'b000); step();
        v0 = 1'b0;
        drain(20);

        // Stall for 5 cycles with three ops in flight and junk on the inputs
        drive0(32'h40000000, 32'h40400000, 4'd9,  32'h40C00000, 3'b000); step();
        drive0(32'h3F800000, 32'h3F800000, 4'd10, 32'h3F800000, 3'b000); step();
        drive0(32'hC0000000, 32'h40000000, 4'd11, 32'hC0800000, 3'b000); step();
        ce = 1'b0; a0 = 32'h12345678; b0 = 32'h3F800000; tag0 = 4'hF;
        repeat (5) step();
        ce = 1'b1;
        drive0(32'h40400000, 32'h40400000, 4'd12, 32'h41100000, 3'b000); step();
        v0 = 1'b0;
        drain(20);

        // Reset with two ops in flight, asserted while ce is low
        drive0(32'h40000000, 32'h40000000, 4'd13, 32'h40800000, 3'b000); step();
        drive0(32'h40400000, 32'h40000000, 4'd14, 32'h40C00000, 3'b000); step();
        v0 = 1'b0; rst = 1'b0; ce = 1'b0;
        step();
        chk("rst_flush_valid", 64'(ov0), 64'(0));
        chk("rst_flush_res", 64'(res0), 64'(0));
        rst = 1'b1; ce = 1'b1;
        repeat (6) step();
        drive0(32'h3F800000, 32'h40000000, 4'd15, 32'h40000000, 3'b000); step();
        v0 = 1'b0;
        drain(20);

        // Random operands with specials on both instances, random ce stalls
        for (int i = 0; i < 10000; i++) begin
            ce = ($urandom_range(0, 9) != 0);
            ra = rnd_op(8, 23); rb = rnd_op(8, 23);
            r  = ref_mul(ra, rb, 8, 23);
            drive0(ra, rb, 4'($urandom), r[31:0], r[34:32]);
            v0 = ($urandom_range(0, 3) != 0);
            ra = rnd_op(5, 10); rb = rnd_op(5, 10);
            r  = ref_mul(ra, rb, 5, 10);
            drive1(ra[15:0], rb[15:0], 4'($urandom), r[31:0], r[34:32]);
            v1 = ($urandom_range(0, 3) != 0);
            step();
        end
        v0 = 1'b0; v1 = 1'b0; ce = 1'b1;
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
